// File: rtl/bus_owner_ctrl_pkg.sv
// Shared definitions for the bus ownership controller: requester count,
// owner index width, tenure counter width and the FSM state encoding.
package bus_owner_ctrl_pkg;

    localparam int NUM_REQ = 5;
    localparam int ID_W    = 3;
    localparam int TEN_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/bus_owner_ctrl_if.sv
// Arbiter-side bundle: one-hot grants and transfer completion in, ownership
// status, freeze request and bookkeeping out.
interface bus_owner_ctrl_if
    import bus_owner_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic             gnt0;
    logic             gnt1;
    logic             gnt2;
    logic             gnt3;
    logic             gnt4;
    logic             xfer_done;
    logic             owner_valid;
    logic [ID_W-1:0]  owner_id;
    logic             hold;
    logic             tenure_expired;
    logic             gnt_err;
    logic [CNT_W-1:0] grant_total;

    // Controller side
    modport slave (
        input  gnt0, gnt1, gnt2, gnt3, gnt4, xfer_done,
        output owner_valid, owner_id, hold, tenure_expired, gnt_err, grant_total
    );

    // Arbiter / environment side
    modport master (
        output gnt0, gnt1, gnt2, gnt3, gnt4, xfer_done,
        input  owner_valid, owner_id, hold, tenure_expired, gnt_err, grant_total
    );

endinterface

// File: rtl/bus_owner_ctrl_onehot5_enc.sv
// Combinational 5-way grant encoder: index of the set grant plus
// exactly-one / more-than-one indications.
module onehot5_enc
    import bus_owner_ctrl_pkg::*;
(
    input  logic            gnt0,
    input  logic            gnt1,
    input  logic            gnt2,
    input  logic            gnt3,
    input  logic            gnt4,
    output logic [ID_W-1:0] idx,
    output logic            is_onehot,
    output logic            multi_hot
);

    logic [NUM_REQ-1:0] vec;
    logic [2:0]         cnt;

    assign vec = {gnt4, gnt3, gnt2, gnt1, gnt0};

    // Population count and index; idx is only meaningful when exactly one bit is set
    always_comb begin
        cnt = 3'd0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                cnt = cnt + 3'd1;
                idx = ID_W'(i);
            end
        end
        is_onehot = (cnt == 3'd1);
        multi_hot = (cnt > 3'd1);
    end

endmodule

// File: rtl/bus_owner_ctrl.sv
// Bus ownership controller: latches a single grant from the upstream
// arbiter, holds it for a bounded tenure, then inserts one release cycle.
module bus_owner_ctrl
    import bus_owner_ctrl_pkg::*;
#(
    parameter int MAX_TENURE = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    bus_owner_ctrl_if.slave  bus
);

    localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);

    state_e           state_q, state_d;
    logic [TEN_W-1:0] tenure_q, tenure_d;
    logic [ID_W-1:0]  owner_id_q, owner_id_d;
    logic             owner_valid_q, owner_valid_d;
    logic             hold_q, hold_d;
    logic             expired_q, expired_d;
    logic             gnt_err_q, gnt_err_d;
    logic [CNT_W-1:0] grant_total_q, grant_total_d;

    logic [ID_W-1:0]  enc_idx;
    logic             enc_onehot;
    logic             enc_multi;

    onehot5_enc u_enc (
        .gnt0      (bus.gnt0),
        .gnt1      (bus.gnt1),
        .gnt2      (bus.gnt2),
        .gnt3      (bus.gnt3),
        .gnt4      (bus.gnt4),
        .idx       (enc_idx),
        .is_onehot (enc_onehot),
        .multi_hot (enc_multi)
    );

    // Next-state and registered-output computation; the expiry pulse defaults low
    always_comb begin
        state_d       = state_q;
        tenure_d      = tenure_q;
        owner_id_d    = owner_id_q;
        owner_valid_d = owner_valid_q;
        hold_d        = hold_q;
        expired_d     = 1'b0;
        gnt_err_d     = gnt_err_q;
        grant_total_d = grant_total_q;

        case (state_q)
            IDLE: begin
                if (enc_onehot) begin
                    state_d       = OWN;
                    owner_valid_d = 1'b1;
                    owner_id_d    = enc_idx;
                    hold_d        = 1'b1;
                    tenure_d      = '0;
                    if (grant_total_q != {CNT_W{1'b1}}) begin
                        grant_total_d = grant_total_q + CNT_W'(1);
                    end
                end else if (enc_multi) begin
                    gnt_err_d = 1'b1;
                end
            end
            OWN: begin
                // Completion takes priority over expiry on the same cycle
                if (bus.xfer_done || (tenure_q == TEN_LAST)) begin
                    state_d       = RELEASE;
                    owner_valid_d = 1'b0;
                    owner_id_d    = '0;
                    hold_d        = 1'b1;
                    expired_d     = ~bus.xfer_done;
                end else begin
                    tenure_d = tenure_q + TEN_W'(1);
                end
            end
            RELEASE: begin
                state_d  = IDLE;
                hold_d   = 1'b0;
                tenure_d = '0;
            end
            default: begin
                state_d       = IDLE;
                owner_valid_d = 1'b0;
                owner_id_d    = '0;
                hold_d        = 1'b0;
                tenure_d      = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            tenure_q      <= '0;
            owner_id_q    <= '0;
            owner_valid_q <= 1'b0;
            hold_q        <= 1'b0;
            expired_q     <= 1'b0;
            gnt_err_q     <= 1'b0;
            grant_total_q <= '0;
        end else begin
            state_q       <= state_d;
            tenure_q      <= tenure_d;
            owner_id_q    <= owner_id_d;
            owner_valid_q <= owner_valid_d;
            hold_q        <= hold_d;
            expired_q     <= expired_d;
            gnt_err_q     <= gnt_err_d;
            grant_total_q <= grant_total_d;
        end
    end

    assign bus.owner_valid    = owner_valid_q;
    assign bus.owner_id       = owner_id_q;
    assign bus.hold           = hold_q;
    assign bus.tenure_expired = expired_q;
    assign bus.gnt_err        = gnt_err_q;
    assign bus.grant_total    = grant_total_q;

endmodule

// File: tb/tb_bus_owner_ctrl.sv
// Scoreboard bench for bus_owner_ctrl: the driver pushes hand-computed
// expected outputs per cycle, a negedge monitor pops and compares.
// A second instance with CNT_W=2 runs the same stimulus to cover saturation.
module tb_bus_owner_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [4:0] G0 = 5'b00001;
    localparam logic [4:0] G1 = 5'b00010;
    localparam logic [4:0] G2 = 5'b00100;
    localparam logic [4:0] G3 = 5'b01000;
    localparam logic [4:0] G4 = 5'b10000;
    localparam logic [4:0] GN = 5'b00000;

    typedef struct {
        int          cyc;
        logic [14:0] v;    // {owner_valid, owner_id[2:0], hold, tenure_expired, gnt_err, grant_total[7:0]}
        logic [1:0]  t2;   // grant_total of the CNT_W=2 instance
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [14:0] act8;

    bus_owner_ctrl_if #(.CNT_W(8)) bus8 ();
    bus_owner_ctrl_if #(.CNT_W(2)) bus2 ();

    bus_owner_ctrl #(.MAX_TENURE(8), .CNT_W(8)) dut8 (
        .clock (clk),
        .reset (rst),
        .bus   (bus8)
    );

    bus_owner_ctrl #(.MAX_TENURE(8), .CNT_W(2)) dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: compare both instances against the queued expectation for this cycle
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc <= cyc_n) begin
            mon_e = sbq.pop_front();
            act8 = {bus8.owner_valid, bus8.owner_id, bus8.hold, bus8.tenure_expired,
                    bus8.gnt_err, bus8.grant_total};
            n_chk++;
            if (mon_e.cyc == cyc_n && act8 === mon_e.v) n_pass++;
            else $display("FAIL %s cyc=%0d: got %h want %h (ov,id,hold,expired,err,total)",
                          mon_e.name, cyc_n, act8, mon_e.v);
            n_chk++;
            if (mon_e.cyc == cyc_n && bus2.grant_total === mon_e.t2) n_pass++;
            else $display("FAIL %s_sat cyc=%0d: got total2=%0d want %0d",
                          mon_e.name, cyc_n, bus2.grant_total, mon_e.t2);
        end
    end

    // Apply inputs for the next edge and queue the outputs expected after it
    task automatic step(input string nm, input logic r, input logic [4:0] g, input logic d,
                        input logic ov, input int id, input logic h, input logic ex,
                        input logic er, input int tot);
        exp_t e;
        rst = r;
        {bus8.gnt4, bus8.gnt3, bus8.gnt2, bus8.gnt1, bus8.gnt0} = g;
        {bus2.gnt4, bus2.gnt3, bus2.gnt2, bus2.gnt1, bus2.gnt0} = g;
        bus8.xfer_done = d;
        bus2.xfer_done = d;
        e.cyc  = cyc_n + 1;
        e.v    = {ov, 3'(id), h, ex, er, 8'(tot)};
        e.t2   = (tot > 3) ? 2'd3 : 2'(tot);
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step("reset0", 1, GN, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, G3, 1, 0, 0, 0, 0, 0, 0);

        // Single grant, done on third OWN cycle; grants ignored in OWN and RELEASE
        step("early_acc", 0, G2, 0, 1, 2, 1, 0, 0, 1);
        step("early_own2", 0, G0, 0, 1, 2, 1, 0, 0, 1);
        step("early_own3", 0, GN, 0, 1, 2, 1, 0, 0, 1);
        step("early_rel", 0, GN, 1, 0, 0, 1, 0, 0, 1);
        step("early_idle", 0, G1, 0, 0, 0, 0, 0, 0, 1);

        // Forced release with gnt4 held, then earliest re-acceptance
        step("force_acc", 0, G4, 0, 1, 4, 1, 0, 0, 2);
        for (int i = 0; i < 7; i++) step("force_own", 0, G4, 0, 1, 4, 1, 0, 0, 2);
        step("force_rel", 0, G4, 0, 0, 0, 1, 1, 0, 2);
        step("force_idle", 0, G4, 0, 0, 0, 0, 0, 0, 2);
        step("force_reacc", 0, G4, 0, 1, 4, 1, 0, 0, 3);
        step("force_rel2", 0, G4, 1, 0, 0, 1, 0, 0, 3);
        step("force_idle2", 0, G0, 0, 0, 0, 0, 0, 0, 3);

        // Done coinciding with the last tenure cycle: no expiry
        step("coin_acc", 0, G0, 0, 1, 0, 1, 0, 0, 4);
        for (int i = 0; i < 7; i++) step("coin_own", 0, GN, 0, 1, 0, 1, 0, 0, 4);
        step("coin_rel", 0, GN, 1, 0, 0, 1, 0, 0, 4);
        step("coin_idle", 0, GN, 0, 0, 0, 0, 0, 0, 4);

        // Multi-hot grant sets sticky error; a later single grant still accepted
        step("multi_err", 0, G0 | G3, 0, 0, 0, 0, 0, 1, 4);
        step("multi_hold", 0, GN, 0, 0, 0, 0, 0, 1, 4);
        step("multi_acc", 0, G1, 0, 1, 1, 1, 0, 1, 5);
        step("multi_rel", 0, GN, 1, 0, 0, 1, 0, 1, 5);
        step("multi_idle", 0, GN, 0, 0, 0, 0, 0, 1, 5);

        // Reset on fourth OWN cycle clears everything
        step("rstown_acc", 0, G3, 0, 1, 3, 1, 0, 1, 6);
        for (int i = 0; i < 3; i++) step("rstown_own", 0, GN, 0, 1, 3, 1, 0, 1, 6);
        step("rstown_rst", 1, GN, 0, 0, 0, 0, 0, 0, 0);

        // Grant sampled on first edge after reset; reset on expiry edge gives no pulse
        step("rstexp_acc", 0, G2, 0, 1, 2, 1, 0, 0, 1);
        for (int i = 0; i < 7; i++) step("rstexp_own", 0, GN, 0, 1, 2, 1, 0, 0, 1);
        step("rstexp_rst", 1, GN, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back single grants; the CNT_W=2 instance saturates at 3
        for (int k = 0; k < 5; k++) begin
            step("sat_acc", 0, 5'(1 << k), 0, 1, k, 1, 0, 0, k + 1);
            step("sat_rel", 0, GN, 1, 0, 0, 1, 0, 0, k + 1);
            step("sat_idle", 0, GN, 0, 0, 0, 0, 0, 0, k + 1);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_owner_ctrl.md
BUS_OWNER_CTRL -- requirements
Module: bus_owner_ctrl

Interface
REQ-001 Parameter MAX_TENURE, default 8, SHALL set the maximum number of owner cycles per grant (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of grant_total.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 gnt0..gnt4  input  1 each  SHALL be the one-hot grants from the upstream 5-way priority arbiter.
REQ-006 xfer_done  input  1  SHALL indicate that the current owner finishes its transfer this cycle.
REQ-007 owner_valid  output  1  SHALL be high while a requester owns the bus.
REQ-008 owner_id  output  3  SHALL be the encoded owner index (0..4), which is valid only when owner_valid is high.
REQ-009 hold  output  1  SHALL be high in OWN and RELEASE, telling the arbiter to freeze its grants.
REQ-010 tenure_expired  output  1  SHALL be a one-cycle pulse marking a forced release.
REQ-011 gnt_err  output  1  SHALL be a sticky flag for a multi-hot grant sampled in IDLE.
REQ-012 grant_total  output  CNT_W  SHALL be a saturating count of accepted grants.

Function
REQ-013 FSM states SHALL be IDLE, OWN and RELEASE, with all outputs registered.
REQ-014 IDLE: exactly one gntN high at edge N -> OWN; owner_id=N, owner_valid=1, tenure=0 from cycle N+1.
REQ-015 IDLE: all gnt low -> stay in IDLE, no output change.
REQ-016 IDLE: two or more gnt high -> stay in IDLE, gnt_err=1 (sticky until reset), no ownership, grant_total unchanged.
REQ-017 OWN: gnt inputs SHALL be ignored; owner_id SHALL remain stable for the whole tenure.
REQ-018 OWN: each cycle with xfer_done=0 and tenure<MAX_TENURE-1 -> tenure+1, stay in OWN.
REQ-019 OWN: xfer_done=1 -> RELEASE, tenure_expired=0.
REQ-020 OWN: tenure==MAX_TENURE-1 and xfer_done=0 -> RELEASE, tenure_expired=1 during the RELEASE cycle only.
REQ-021 If xfer_done and expiry coincide, xfer_done SHALL win and no expiry pulse SHALL be produced.
REQ-022 owner_valid SHALL be high for at most MAX_TENURE consecutive cycles.
REQ-023 RELEASE SHALL last exactly one cycle with owner_valid=0 and hold=1, then -> IDLE, where hold=0.
REQ-024 The earliest next acceptance SHALL occur at the IDLE cycle following RELEASE, giving a two-cycle minimum gap between tenures.
REQ-025 grant_total SHALL increment on each IDLE->OWN transition and hold at all-ones (no wrap).
REQ-026 owner_id SHALL read 0 whenever owner_valid=0.

Reset
REQ-027 With reset=1 at an edge, the next state SHALL be IDLE, and owner_valid, owner_id, hold, tenure_expired, gnt_err, grant_total and tenure SHALL all be 0.
REQ-028 Reset SHALL override every other input, including mid-OWN and mid-RELEASE; no tenure_expired pulse SHALL be produced by reset.
REQ-029 After reset deasserts, the first gnt sample SHALL be taken at the next edge.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/OWN/RELEASE), NUM_REQ=5 and ID_W=3.
REQ-031 One combinational sub-module, onehot5_enc, SHALL produce the index plus an is_onehot/multi_hot indication from gnt0..gnt4.
REQ-032 The tenure counter width SHALL be 8 bits, sufficient for MAX_TENURE<=255.

Verification
REQ-033 Single grant with early done: gnt2=1 for one cycle, xfer_done on the 3rd OWN cycle -> owner_valid high for 3 cycles, owner_id=2, then one RELEASE cycle, grant_total=1, tenure_expired never asserted.
REQ-034 Forced release: gnt4 held, xfer_done=0 throughout -> owner_valid high for exactly 8 cycles, then tenure_expired=1 for 1 cycle and hold drops one cycle later.
REQ-035 Multi-hot grant: gnt0=gnt3=1 in IDLE -> gnt_err=1 from next cycle and stays set, owner_valid=0, grant_total=0; a later gnt1 is still accepted.
REQ-036 Coincident events: xfer_done=1 on the 8th OWN cycle -> RELEASE with tenure_expired=0.
REQ-037 Reset mid-OWN: reset=1 on the 4th OWN cycle -> all outputs 0 next cycle, no tenure_expired pulse, grant_total cleared.
REQ-038 Saturation: CNT_W=2 with 5 back-to-back single grants -> grant_total sequence 1,2,3,3,3.
